// File: rtl/multi_port_fifo_pkg.sv
// Shared helpers for the multi-lane FIFO: width calculations used by the interface,
// the top and the RAM so that every per-cycle count field agrees on its size.
package multi_port_fifo_pkg;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  // A per-cycle count must be able to hold 0..ways, i.e. ways+1 distinct values.
  function automatic int cnt_width(input int ways);
    return clog2(ways + 1);
  endfunction

endpackage

// File: rtl/multi_port_fifo_if.sv
// Handshake and status bundle of the multi-lane FIFO; the producer/consumer side is
// the master, the FIFO itself is the slave.
interface multi_port_fifo_if
  import multi_port_fifo_pkg::*;
#(
  parameter int kWidth     = 32,
  parameter int kAddrWidth = 4,
  parameter int kWays      = 2
);
  localparam int kCntW = cnt_width(kWays);

  logic                      flush;
  logic [kCntW-1:0]          write_num;
  logic [kWays*kWidth-1:0]   write_data;
  logic [kCntW-1:0]          read_num;
  logic [kWays*kWidth-1:0]   read_data;
  logic [kWays-1:0]          read_valid;
  logic [kAddrWidth:0]       count;
  logic [kAddrWidth:0]       free_slots;
  logic                      is_full;
  logic                      is_empty;
  logic                      almost_full;
  logic                      overflow;
  logic                      underflow;

  modport master (
    output flush, write_num, write_data, read_num,
    input  read_data, read_valid, count, free_slots, is_full, is_empty,
           almost_full, overflow, underflow
  );

  modport slave (
    input  flush, write_num, write_data, read_num,
    output read_data, read_valid, count, free_slots, is_full, is_empty,
           almost_full, overflow, underflow
  );

endinterface

// File: rtl/multi_port_fifo_ram_mp.sv
// Storage array with kWays write lanes and kWays asynchronous read lanes. Lane
// addresses are consecutive from a base, so lanes never collide within one cycle.
module fifo_ram_mp
  import multi_port_fifo_pkg::*;
#(
  parameter int kWidth     = 32,
  parameter int kAddrWidth = 4,
  parameter int kWays      = 2
)(
  input  logic                        clk,
  input  logic [cnt_width(kWays)-1:0] write_num,
  input  logic [kAddrWidth-1:0]       write_base,
  input  logic [kWays*kWidth-1:0]     write_data,
  input  logic [kAddrWidth-1:0]       read_base,
  output logic [kWays*kWidth-1:0]     read_data
);
  localparam int kSize = 1 << kAddrWidth;

  logic [kWidth-1:0] mem [kSize];

  // Lane i is enabled when it falls below write_num; contents are never reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < kWays; i++) begin
      if (int'(write_num) > i)
        mem[write_base + kAddrWidth'(i)] <= write_data[i*kWidth +: kWidth];
    end
  end

  always_comb begin
    read_data = '0;
    for (int i = 0; i < kWays; i++)
      read_data[i*kWidth +: kWidth] = mem[read_base + kAddrWidth'(i)];
  end

endmodule

// File: rtl/multi_port_fifo.sv
// Multi-lane first-word-fall-through FIFO: up to kWays pushes and pops per cycle,
// with occupancy status and sticky overflow/underflow flags.
module multi_port_fifo
  import multi_port_fifo_pkg::*;
#(
  parameter int kWidth            = 32,
  parameter int kAddrWidth        = 4,
  parameter int kWays             = 2,
  parameter int kAlmostFullMargin = 2
)(
  input logic              clk,
  input logic              rst,
  multi_port_fifo_if.slave bus
);
  localparam int kSize = 1 << kAddrWidth;
  localparam int kPtrW = kAddrWidth + 1;
  localparam int kCntW = cnt_width(kWays);

  logic [kPtrW-1:0]        read_ptr;
  logic [kPtrW-1:0]        write_ptr;
  logic [kPtrW-1:0]        count_q;
  logic [kPtrW-1:0]        free_q;
  logic                    overflow_q;
  logic                    underflow_q;
  logic                    read_ok;
  logic                    write_ok;
  logic                    commit;
  logic [kCntW-1:0]        ram_write_num;
  logic [kWays*kWidth-1:0] ram_read_data;

  assign count_q = write_ptr - read_ptr;
  assign free_q  = kPtrW'(kSize) - count_q;

  // A write may consume the space released by a read accepted in the same cycle.
  always_comb begin
    read_ok  = (int'(bus.read_num) <= kWays) && (int'(bus.read_num) <= int'(count_q));
    write_ok = (int'(bus.write_num) <= kWays) &&
               (int'(bus.write_num) <= int'(free_q) + (read_ok ? int'(bus.read_num) : 0));
  end

  assign commit        = rst && !bus.flush;
  assign ram_write_num = (commit && write_ok) ? bus.write_num : '0;

  always_ff @(posedge clk) begin
    if (!rst || bus.flush) begin
      read_ptr    <= '0;
      write_ptr   <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (read_ok) read_ptr <= read_ptr + kPtrW'(bus.read_num);
      else         underflow_q <= 1'b1;
      if (write_ok) write_ptr <= write_ptr + kPtrW'(bus.write_num);
      else          overflow_q <= 1'b1;
    end
  end

  fifo_ram_mp #(
    .kWidth     (kWidth),
    .kAddrWidth (kAddrWidth),
    .kWays      (kWays)
  ) u_ram (
    .clk        (clk),
    .write_num  (ram_write_num),
    .write_base (write_ptr[kAddrWidth-1:0]),
    .write_data (bus.write_data),
    .read_base  (read_ptr[kAddrWidth-1:0]),
    .read_data  (ram_read_data)
  );

  // Lanes beyond the current occupancy are masked to zero so stale memory never leaks.
  always_comb begin
    bus.read_valid = '0;
    bus.read_data  = '0;
    for (int i = 0; i < kWays; i++) begin
      bus.read_valid[i] = count_q > kPtrW'(i);
      if (bus.read_valid[i])
        bus.read_data[i*kWidth +: kWidth] = ram_read_data[i*kWidth +: kWidth];
    end
  end

  assign bus.count       = count_q;
  assign bus.free_slots  = free_q;
  assign bus.is_full     = (count_q == kPtrW'(kSize));
  assign bus.is_empty    = (count_q == '0);
  assign bus.almost_full = (int'(count_q) >= kSize - kAlmostFullMargin);
  assign bus.overflow    = overflow_q;
  assign bus.underflow   = underflow_q;

endmodule

// File: tb/tb_multi_port_fifo.sv
// Directed bench for multi_port_fifo at 8-bit width, depth 4, two lanes, margin 1:
// a vector table walking through reset, fill, wrap, flush and error cases.
module tb_multi_port_fifo;

  logic clk;
  logic rst;

  typedef struct {
    logic        rst;
    logic        flush;
    logic [1:0]  wn;
    logic [15:0] wd;
    logic [1:0]  rn;
    int          cnt;
    logic [1:0]  valid;
    logic [15:0] data;
    logic        ovf;
    logic        udf;
  } vec_t;

  vec_t vecs[$];
  int   vectors_applied;
  int   miscompares;

  multi_port_fifo_if #(.kWidth(8), .kAddrWidth(2), .kWays(2)) bus ();

  multi_port_fifo #(
    .kWidth            (8),
    .kAddrWidth        (2),
    .kWays             (2),
    .kAlmostFullMargin (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add_vec(input logic r, input logic f, input logic [1:0] wn,
                         input logic [15:0] wd, input logic [1:0] rn, input int cnt,
                         input logic [1:0] valid, input logic [15:0] data,
                         input logic ovf, input logic udf);
    vecs.push_back('{r, f, wn, wd, rn, cnt, valid, data, ovf, udf});
  endtask

  task automatic apply_stimulus(input vec_t v);
    rst            = v.rst;
    bus.flush      = v.flush;
    bus.write_num  = v.wn;
    bus.write_data = v.wd;
    bus.read_num   = v.rn;
    @(posedge clk);
    #1;
  endtask

  // Status flags are derived here from the expected occupancy (depth 4, almost-full at 3).
  task automatic check_output(input string tag, input int ecnt, input logic [1:0] evalid,
                              input logic [15:0] edata, input logic eovf, input logic eudf);
    bit bad;
    bad = 0;
    vectors_applied++;
    if (bus.count !== 3'(ecnt)) begin
      $display("[TB] FAIL %s count: got %0d want %0d", tag, bus.count, ecnt); bad = 1;
    end
    if (bus.free_slots !== 3'(4 - ecnt)) begin
      $display("[TB] FAIL %s free_slots: got %0d want %0d", tag, bus.free_slots, 4 - ecnt); bad = 1;
    end
    if (bus.is_full !== (ecnt == 4)) begin
      $display("[TB] FAIL %s is_full: got %b want %b", tag, bus.is_full, ecnt == 4); bad = 1;
    end
    if (bus.is_empty !== (ecnt == 0)) begin
      $display("[TB] FAIL %s is_empty: got %b want %b", tag, bus.is_empty, ecnt == 0); bad = 1;
    end
    if (bus.almost_full !== (ecnt >= 3)) begin
      $display("[TB] FAIL %s almost_full: got %b want %b", tag, bus.almost_full, ecnt >= 3); bad = 1;
    end
    if (bus.read_valid !== evalid) begin
      $display("[TB] FAIL %s read_valid: got %b want %b", tag, bus.read_valid, evalid); bad = 1;
    end
    if (bus.read_data !== edata) begin
      $display("[TB] FAIL %s read_data: got %h want %h", tag, bus.read_data, edata); bad = 1;
    end
    if (bus.overflow !== eovf) begin
      $display("[TB] FAIL %s overflow: got %b want %b", tag, bus.overflow, eovf); bad = 1;
    end
    if (bus.underflow !== eudf) begin
      $display("[TB] FAIL %s underflow: got %b want %b", tag, bus.underflow, eudf); bad = 1;
    end
    if (bad) miscompares++;
  endtask

  initial begin
    vectors_applied = 0;
    miscompares     = 0;
    rst             = 1'b0;
    bus.flush       = 1'b0;
    bus.write_num   = '0;
    bus.write_data  = '0;
    bus.read_num    = '0;

    //      rst flush wn  wd        rn  cnt valid  data      ovf udf
    add_vec(0, 0, 2'd0, 16'h0000, 2'd0, 0, 2'b00, 16'h0000, 0, 0);
    add_vec(0, 0, 2'd0, 16'h0000, 2'd0, 0, 2'b00, 16'h0000, 0, 0);
    add_vec(1, 0, 2'd2, 16'h2211, 2'd0, 2, 2'b11, 16'h2211, 0, 0);
    add_vec(1, 0, 2'd0, 16'h0000, 2'd1, 1, 2'b01, 16'h0022, 0, 0);
    add_vec(1, 0, 2'd2, 16'h4433, 2'd0, 3, 2'b11, 16'h3322, 0, 0);
    add_vec(1, 0, 2'd1, 16'h0055, 2'd0, 4, 2'b11, 16'h3322, 0, 0);
    add_vec(1, 0, 2'd1, 16'h0066, 2'd0, 4, 2'b11, 16'h3322, 1, 0);
    add_vec(1, 0, 2'd2, 16'hA1A0, 2'd2, 4, 2'b11, 16'h5544, 1, 0);
    add_vec(1, 0, 2'd2, 16'hA3A2, 2'd2, 4, 2'b11, 16'hA1A0, 1, 0);
    add_vec(1, 0, 2'd2, 16'hB1B0, 2'd2, 4, 2'b11, 16'hA3A2, 1, 0);
    add_vec(1, 0, 2'd0, 16'h0000, 2'd2, 2, 2'b11, 16'hB1B0, 1, 0);
    add_vec(1, 0, 2'd0, 16'h0000, 2'd1, 1, 2'b01, 16'h00B1, 1, 0);
    add_vec(1, 0, 2'd1, 16'h00C0, 2'd0, 2, 2'b11, 16'hC0B1, 1, 0);
    add_vec(1, 1, 2'd2, 16'hDDCC, 2'd0, 0, 2'b00, 16'h0000, 0, 0);
    add_vec(1, 0, 2'd0, 16'h0000, 2'd0, 0, 2'b00, 16'h0000, 0, 0);
    add_vec(1, 0, 2'd0, 16'h0000, 2'd1, 0, 2'b00, 16'h0000, 0, 1);
    add_vec(1, 0, 2'd2, 16'hE1E0, 2'd0, 2, 2'b11, 16'hE1E0, 0, 1);
    add_vec(0, 0, 2'd2, 16'hF1F0, 2'd0, 0, 2'b00, 16'h0000, 0, 0);
    add_vec(1, 0, 2'd0, 16'h0000, 2'd0, 0, 2'b00, 16'h0000, 0, 0);
    add_vec(1, 0, 2'd3, 16'h7777, 2'd0, 0, 2'b00, 16'h0000, 1, 0);
    add_vec(1, 0, 2'd2, 16'h1234, 2'd0, 2, 2'b11, 16'h1234, 1, 0);
    add_vec(1, 0, 2'd0, 16'h0000, 2'd3, 2, 2'b11, 16'h1234, 1, 1);
    add_vec(1, 0, 2'd1, 16'h0056, 2'd0, 3, 2'b11, 16'h1234, 1, 1);
    add_vec(1, 0, 2'd2, 16'h9988, 2'd0, 3, 2'b11, 16'h1234, 1, 1);
    add_vec(1, 0, 2'd2, 16'h9988, 2'd1, 4, 2'b11, 16'h5612, 1, 1);
    add_vec(1, 1, 2'd0, 16'h0000, 2'd0, 0, 2'b00, 16'h0000, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i]);
      check_output($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].valid, vecs[i].data,
                   vecs[i].ovf, vecs[i].udf);
    end

    // A push must not appear on read_data until after its clock edge.
    bus.flush      = 1'b0;
    bus.write_num  = 2'd1;
    bus.write_data = 16'h0077;
    bus.read_num   = 2'd0;
    #2;
    check_output("no_bypass", 0, 2'b00, 16'h0000, 0, 0);
    @(posedge clk);
    #1;
    bus.write_num = 2'd0;
    check_output("fwft_visible", 1, 2'b01, 16'h0077, 0, 0);

    // A pop leaves the head in place until the edge, then the FIFO drains.
    bus.read_num = 2'd1;
    #2;
    check_output("pop_pending", 1, 2'b01, 16'h0077, 0, 0);
    @(posedge clk);
    #1;
    bus.read_num = 2'd0;
    check_output("pop_done", 0, 2'b00, 16'h0000, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
